// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the M-stage coprocessor-0.
//   - CP0 register indices (BadVAddr, Count, Compare, SR, Cause, EPC, PRId)
//   - SR / Cause field bit positions
//   - ExcCode values used by the pipeline
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // SR fields
    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;

    // Cause fields
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/m_cp0_timer_if.sv
// m_cp0_timer_if: pipeline <-> CP0 signal bundle.
//   master : the M-stage pipeline (drives mtc0/exception info, hwint)
//   slave  : the CP0 block (returns rdata, epc_out, req, timer_irq)
// req is a single-cycle strobe: when it is high at a clock edge the CP0 has
// committed the exception/interrupt; there is no back-pressure from the pipe.
interface m_cp0_timer_if #(
    parameter int N_HWINT = 6
);
    logic                 we;
    logic [4:0]           addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic [31:0]          vpc;
    logic                 bd_in;
    logic [4:0]           exc_code_in;
    logic [31:0]          badvaddr_in;
    logic [N_HWINT-1:0]   hwint;
    logic                 exl_clr;
    logic [31:0]          epc_out;
    logic                 req;
    logic                 timer_irq;

    modport master (
        output we, addr, wdata, vpc, bd_in, exc_code_in, badvaddr_in, hwint, exl_clr,
        input  rdata, epc_out, req, timer_irq
    );

    modport slave (
        input  we, addr, wdata, vpc, bd_in, exc_code_in, badvaddr_in, hwint, exl_clr,
        output rdata, epc_out, req, timer_irq
    );
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer.
//   clk, reset     : clock, asynchronous active-low reset
//   count_ld       : load Count from wdata and clear the prescaler
//   compare_ld     : load Compare from wdata and clear TI
//   wdata          : load data
//   count, compare : current register values
//   ti             : sticky timer-interrupt flag
// Count advances every second cycle via a 1-bit prescaler.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_ld,
    input  logic        compare_ld,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic        presc_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ti_q;
    logic        inc;
    logic [31:0] count_inc;

    // A Count load in an increment cycle suppresses the increment.
    assign inc       = presc_q & ~count_ld;
    assign count_inc = count_q + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q <= count_ld ? 1'b0 : ~presc_q;
            if (count_ld)
                count_q <= wdata;
            else if (inc)
                count_q <= count_inc;
            // Compare load beats a coincident match.
            if (compare_ld) begin
                compare_q <= wdata;
                ti_q      <= 1'b0;
            end else if (inc && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/m_cp0_timer.sv
// m_cp0_timer: M-stage coprocessor-0 with SR, Cause, EPC, BadVAddr,
// Count/Compare timer, PRId and N_HWINT external interrupt lines.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : m_cp0_timer_if.slave -- mtc0 write/read port, M-stage PC,
//            delay-slot flag, exception code, faulting address, hwint,
//            eret clear; returns rdata, epc_out, req and timer_irq.
// Each cycle the block arbitrates interrupt > exception > mtc0 write.
module m_cp0_timer
    import cp0_pkg::*;
#(
    parameter int          N_HWINT  = 6,
    parameter bit          TIMER_EN = 1'b1,
    parameter logic [31:0] SR_RESET = 32'h1000_0000,
    parameter logic [31:0] PRID     = 32'h0000_0007
) (
    input  logic           clk,
    input  logic           reset,
    m_cp0_timer_if.slave   bus
);
    logic [31:0] sr_q, sr_next;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [4:0]  exc_code_q;
    logic        bd_q;
    logic [5:0]  ip_q, ip_next;
    logic [31:0] count, compare;
    logic        ti;
    logic        int_req, exc_req, take, wr_ok;
    logic        count_ld, compare_ld;
    logic [31:0] cause_word;
    logic [31:0] rdata_i;

    // IP is evaluated ahead of the latch so hwint reaches req with no delay.
    always_comb begin
        ip_next = '0;
        for (int k = 0; k < N_HWINT; k++)
            ip_next[k] = bus.hwint[k];
        ip_next[5] = ip_next[5] | ti;
    end

    assign int_req = (|(ip_next & sr_q[SR_IM_HI:SR_IM_LO])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
    assign exc_req = (bus.exc_code_in != EXC_INT) & ~sr_q[SR_EXL];
    assign take    = int_req | exc_req;
    assign wr_ok   = bus.we & ~take;

    assign count_ld   = wr_ok && (bus.addr == REG_COUNT);
    assign compare_ld = wr_ok && (bus.addr == REG_COMPARE);

    // A taken request forces EXL=1, overriding any eret in the same cycle.
    always_comb begin
        sr_next = sr_q;
        if (take) begin
            sr_next[SR_EXL] = 1'b1;
        end else begin
            if (wr_ok && (bus.addr == REG_SR))
                sr_next = bus.wdata;
            if (bus.exl_clr)
                sr_next[SR_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q       <= SR_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            exc_code_q <= '0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
        end else begin
            sr_q <= sr_next;
            ip_q <= ip_next;
            if (take) begin
                epc_q <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
                bd_q  <= bus.bd_in;
                if (int_req) begin
                    exc_code_q <= EXC_INT;
                end else begin
                    exc_code_q <= bus.exc_code_in;
                    if ((bus.exc_code_in == EXC_ADEL) || (bus.exc_code_in == EXC_ADES))
                        badvaddr_q <= bus.badvaddr_in;
                end
            end else if (wr_ok && (bus.addr == REG_EPC)) begin
                epc_q <= {bus.wdata[31:2], 2'b00};
            end
        end
    end

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_ld   (count_ld),
                .compare_ld (compare_ld),
                .wdata      (bus.wdata),
                .count      (count),
                .compare    (compare),
                .ti         (ti)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign ti      = 1'b0;
        end
    endgenerate

    always_comb begin
        cause_word                            = '0;
        cause_word[CAUSE_BD]                  = bd_q;
        cause_word[CAUSE_TI]                  = ti;
        cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
        cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
    end

    // Reads see pre-edge state; there is no write bypass.
    always_comb begin
        rdata_i = '0;
        case (bus.addr)
            REG_BADVADDR: rdata_i = badvaddr_q;
            REG_COUNT:    rdata_i = count;
            REG_COMPARE:  rdata_i = compare;
            REG_SR:       rdata_i = sr_q;
            REG_CAUSE:    rdata_i = cause_word;
            REG_EPC:      rdata_i = epc_q;
            REG_PRID:     rdata_i = PRID;
            default:      rdata_i = '0;
        endcase
    end

    assign bus.rdata     = rdata_i;
    assign bus.epc_out   = epc_q;
    assign bus.req       = take & reset;
    assign bus.timer_irq = ti;
endmodule

// File: tb/tb_m_cp0_timer.sv
// tb_m_cp0_timer: directed bench for m_cp0_timer with a reference model.
module tb_m_cp0_timer;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   started;

    m_cp0_timer_if #(.N_HWINT(6)) bus ();

    m_cp0_timer #(
        .N_HWINT  (6),
        .TIMER_EN (1'b1),
        .SR_RESET (32'h1000_0000),
        .PRID     (32'h0000_0007)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Count is kept as (value at last load) + (cycles since load)/2.
    logic [31:0] m_sr, m_epc, m_badv, m_cmp, m_base, m_n;
    logic [4:0]  m_exc;
    logic        m_bd, m_ti;
    logic [5:0]  m_ip;

    function automatic logic [5:0] m_ipn();
        return {bus.hwint[5] | m_ti, bus.hwint[4:0]};
    endfunction

    function automatic logic m_int();
        return (|(m_ipn() & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_excr();
        return (bus.exc_code_in != 5'd0) && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_base + (m_n >> 1);
            5'd11:   return m_cmp;
            5'd12:   return m_sr;
            5'd13:   return {m_bd, m_ti, 14'b0, m_ip, 3'b0, m_exc, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0007;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic        ir, er, wr;
        logic [31:0] cur, sr_new;
        if (!reset) begin
            m_sr   <= 32'h1000_0000;
            m_epc  <= '0;
            m_badv <= '0;
            m_cmp  <= '0;
            m_base <= '0;
            m_n    <= '0;
            m_exc  <= '0;
            m_bd   <= 1'b0;
            m_ti   <= 1'b0;
            m_ip   <= '0;
        end else begin
            ir  = m_int();
            er  = m_excr();
            wr  = bus.we && !(ir || er);
            cur = m_base + (m_n >> 1);
            m_ip <= m_ipn();
            if (wr && bus.addr == 5'd9) begin
                m_base <= bus.wdata;
                m_n    <= '0;
            end else begin
                m_n <= m_n + 32'd1;
            end
            if (wr && bus.addr == 5'd11) begin
                m_cmp <= bus.wdata;
                m_ti  <= 1'b0;
            end else if (!(wr && bus.addr == 5'd9) && m_n[0] && (cur + 32'd1 == m_cmp)) begin
                m_ti <= 1'b1;
            end
            if (ir || er) begin
                m_epc <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
                m_bd  <= bus.bd_in;
                m_exc <= ir ? 5'd0 : bus.exc_code_in;
                if (!ir && (bus.exc_code_in == 5'd4 || bus.exc_code_in == 5'd5))
                    m_badv <= bus.badvaddr_in;
                m_sr <= m_sr | 32'h2;
            end else begin
                sr_new = m_sr;
                if (wr && bus.addr == 5'd12) sr_new = bus.wdata;
                if (wr && bus.addr == 5'd14) m_epc <= {bus.wdata[31:2], 2'b00};
                if (bus.exl_clr) sr_new[1] = 1'b0;
                m_sr <= sr_new;
            end
        end
    end

    // Every mid-cycle point the outputs are compared with the model.
    always @(negedge clk) begin
        if (started && reset) begin
            chk("mdl_rdata", bus.rdata, m_read(bus.addr));
            chk("mdl_req", {31'b0, bus.req}, {31'b0, m_int() || m_excr()});
            chk("mdl_epc", bus.epc_out, m_epc);
            chk("mdl_tirq", {31'b0, bus.timer_irq}, {31'b0, m_ti});
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        step();
        bus.we = 1'b0;
    endtask

    int cyc;

    initial begin
        total = 0; bad = 0; started = 1'b0; reset = 1'b0;
        bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.vpc = '0; bus.bd_in = 1'b0;
        bus.exc_code_in = '0; bus.badvaddr_in = '0; bus.hwint = '0; bus.exl_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.req}, 32'h0);
        chk("rst_tirq", {31'b0, bus.timer_irq}, 32'h0);
        chk("rst_epc", bus.epc_out, 32'h0);
        reset = 1'b1;
        started = 1'b1;
        bus.addr = 5'd12; #1 chk("rd_sr", bus.rdata, 32'h1000_0000);
        bus.addr = 5'd13; #1 chk("rd_cause", bus.rdata, 32'h0);
        bus.addr = 5'd15; #1 chk("rd_prid", bus.rdata, 32'h0000_0007);
        chk("idle_req", {31'b0, bus.req}, 32'h0);

        // hardware interrupt in a delay slot
        step();
        mtc0(5'd12, 32'h0000_0401);
        bus.hwint = 6'b000001; bus.vpc = 32'h0000_3010; bus.bd_in = 1'b1;
        #1 chk("int_req", {31'b0, bus.req}, 32'h1);
        step();
        chk("int_req_masked", {31'b0, bus.req}, 32'h0);
        chk("int_epc", bus.epc_out, 32'h0000_300C);
        bus.addr = 5'd13; #1;
        chk("int_bd", {31'b0, bus.rdata[31]}, 32'h1);
        chk("int_exc", {27'b0, bus.rdata[6:2]}, 32'h0);
        bus.addr = 5'd12; #1 chk("int_exl", {31'b0, bus.rdata[1]}, 32'h1);
        bus.hwint = '0; bus.bd_in = 1'b0; bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;

        // AdEL exception
        bus.exc_code_in = 5'd4; bus.badvaddr_in = 32'h0000_3001; bus.vpc = 32'h0000_3000;
        #1 chk("adel_req", {31'b0, bus.req}, 32'h1);
        step();
        bus.exc_code_in = '0;
        bus.addr = 5'd8;  #1 chk("adel_badv", bus.rdata, 32'h0000_3001);
        bus.addr = 5'd13; #1 chk("adel_exc", {27'b0, bus.rdata[6:2]}, 32'h4);
        chk("adel_epc", bus.epc_out, 32'h0000_3000);

        // exception together with eret: EXL must stay set
        bus.exl_clr = 1'b1;
        step();
        bus.exc_code_in = 5'd5; bus.badvaddr_in = 32'h0000_3005; bus.vpc = 32'h0000_3004;
        #1 chk("ades_req", {31'b0, bus.req}, 32'h1);
        step();
        bus.exc_code_in = '0; bus.exl_clr = 1'b0;
        bus.addr = 5'd12; #1 chk("ades_exl", {31'b0, bus.rdata[1]}, 32'h1);
        bus.addr = 5'd8;  #1 chk("ades_badv", bus.rdata, 32'h0000_3005);

        // timer interrupt
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'h3);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.timer_irq) begin
                cyc = i;
                break;
            end
        end
        chk("ti_latency", cyc, 32'd5);
        chk("ti_req", {31'b0, bus.req}, 32'h1);
        step();
        chk("ti_req_taken", {31'b0, bus.req}, 32'h0);
        chk("ti_sticky", {31'b0, bus.timer_irq}, 32'h1);
        bus.addr = 5'd13; #1;
        chk("ti_cause_ti", {31'b0, bus.rdata[30]}, 32'h1);
        chk("ti_cause_ip15", {31'b0, bus.rdata[15]}, 32'h1);
        mtc0(5'd11, 32'd100);
        chk("ti_clear", {31'b0, bus.timer_irq}, 32'h0);
        mtc0(5'd12, 32'h0);

        // mtc0 EPC write dropped by a coincident overflow exception
        bus.exc_code_in = 5'd12; bus.vpc = 32'h0000_5000;
        bus.we = 1'b1; bus.addr = 5'd14; bus.wdata = 32'hABCD_0000;
        #1 chk("ov_req", {31'b0, bus.req}, 32'h1);
        step();
        bus.we = 1'b0; bus.exc_code_in = '0;
        #1 chk("ov_epc", bus.epc_out, 32'h0000_5000);
        mtc0(5'd12, 32'h0);

        // asynchronous reset between clock edges
        mtc0(5'd9, 32'd5);
        bus.addr = 5'd9; #1 chk("pre_rst_count", bus.rdata, 32'd5);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_count", bus.rdata, 32'h0);
        chk("arst_epc", bus.epc_out, 32'h0);
        chk("arst_req", {31'b0, bus.req}, 32'h0);
        bus.addr = 5'd12; #1 chk("arst_sr", bus.rdata, 32'h1000_0000);
        reset = 1'b1;
        bus.addr = 5'd9;
        repeat (6) step();
        chk("post_rst_count", bus.rdata, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_cp0_timer.md
Name: m_cp0_timer

Overview:
- Parametrised next-generation coprocessor-0 for the P7 pipeline, instantiated in the M stage.
- Holds SR(12), Cause(13) and EPC(14), and adds:
  - BadVAddr(8)
  - Count(9)/Compare(11) timer with an internal timer interrupt
  - PRId(15)
  - a configurable number of external interrupt lines
- Arbitrates interrupt vs exception vs mtc0 write each cycle and drives `req` to the pipeline flush/redirect logic.

Parameters:
- N_HWINT, 6, external interrupt lines (1..6); line k maps to IP/IM bit 10+k.
- TIMER_EN, 1, implements Count/Compare; the timer interrupt is ORed onto IP[15].
- SR_RESET, 32'h1000_0000, SR value after reset.
- PRID, 32'h0000_0007, constant returned by PRId reads.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  mtc0 write enable
- addr  in  5  CP0 register index for read and write
- wdata  in  32  mtc0 write data
- rdata  out  32  combinational read of `addr`
- vpc  in  32  PC of the instruction currently in M
- bd_in  in  1  M instruction sits in a delay slot
- exc_code_in  in  5  exception code of M instruction; 0 = none
- badvaddr_in  in  32  faulting address for AdEL/AdES
- hwint  in  N_HWINT  level-sensitive external interrupt lines
- exl_clr  in  1  eret in M; clears SR.EXL
- epc_out  out  32  current EPC
- req  out  1  take exception/interrupt this cycle
- timer_irq  out  1  Cause.TI (pending timer interrupt)

Behaviour:
- Reset (reset=0, asynchronous): SR=SR_RESET; all other registers 0, including the prescaler.
  - Outputs during reset: req=0, timer_irq=0, epc_out=0.
- Field layout:
  - SR: IE=SR[0], EXL=SR[1], IM=SR[15:10].
  - Cause: ExcCode=[6:2], IP=[15:10], TI=[30], BD=[31].
- IP update, every cycle, unconditionally:
  - IP[10+k] <= hwint[k] for k < N_HWINT.
  - Unused IP bits are 0.
  - IP[15] <= (N_HWINT==6 ? hwint[5] : 0) | TI.
- Request logic, combinational:
  - int_req = |(IP_next & IM) & IE & ~EXL, where IP_next is the value about to be latched. Using IP_next gives no extra latency on hwint.
  - exc_req = (exc_code_in != 0) & ~EXL.
  - req = int_req | exc_req.
- Priority at the clock edge:
  1. int_req: ExcCode<=0.
  2. else exc_req: ExcCode<=exc_code_in. If exc_code_in is 4 or 5, BadVAddr<=badvaddr_in.
  3. else we: mtc0 write.
- Common actions on int_req or exc_req:
  - EPC <= bd_in ? vpc-4 : vpc.
  - BD <= bd_in.
  - EXL <= 1.
- exl_clr:
  - Sets EXL<=0 unless req is also asserted in the same cycle; req wins and EXL stays/becomes 1.
  - req is evaluated with the pre-edge EXL.
- mtc0 write rules:
  - SR: full write.
  - EPC: {wdata[31:2], 2'b00}.
  - Count: load wdata and clear the prescaler.
  - Compare: load wdata and clear TI.
  - Cause, BadVAddr, PRId: read-only; writes ignored.
  - Writes dropped in any cycle where req=1.
- Timer (TIMER_EN=1):
  - 1-bit prescaler toggles each cycle; Count increments when the prescaler is 1, i.e. every 2nd cycle. Wraps 32'hFFFF_FFFF -> 0.
  - TI sets on the edge where Count is incremented to a value equal to Compare. TI is sticky until a Compare write.
  - A Count write in an increment cycle: the write wins and no increment occurs.
  - A Compare write and a TI-set in the same cycle: the clear wins.
  - With TIMER_EN=0: Count, Compare and TI read 0; writes are ignored.
- Reads:
  - Unimplemented indices read 0. PRId reads PRID.
  - No write-to-read bypass: a same-cycle read returns the old value.
- epc_out = EPC (registered).
- timer_irq = TI.

Decomposition:
- Shared package cp0_pkg:
  - register index constants: REG_BADVADDR=8, REG_COUNT=9, REG_COMPARE=11, REG_SR=12, REG_CAUSE=13, REG_EPC=14, REG_PRID=15
  - SR/Cause bit-position constants
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12
- One sub-module, cp0_timer: prescaler, Count, Compare and TI, with load/clear inputs and a TI output. Generated only when TIMER_EN=1.

Test Plan:
- Release reset; read addr 12, 13 and 15 -> rdata = 32'h1000_0000, 0 and 32'h0000_0007; req=0.
- Write SR=32'h0000_0401, hold hwint[0]=1, vpc=32'h0000_3010, bd_in=1:
  - req=1 in the same cycle.
  - Next cycle: EPC=32'h0000_300C, Cause[31]=1, ExcCode=0, SR[1]=1.
  - req=0 while hwint stays high.
- exc_code_in=4, badvaddr_in=32'h0000_3001, vpc=32'h0000_3000, bd_in=0 -> BadVAddr=32'h0000_3001, ExcCode=4, EPC=32'h0000_3000.
  - Same test, but assert exl_clr alongside the exception: EXL stays 1.
- Count=0, Compare=3, SR=32'h0000_8001 -> TI and timer_irq rise once Count reaches 3 (≈6 cycles); req=1 the cycle IP[15] is latched.
  - Writing Compare clears TI.
- Assert we=1 to EPC together with exc_code_in=12 -> the write is dropped; EPC=vpc.
- Pulse reset low mid-timer (Count=5) with no clk edge -> all registers return to reset values immediately.
